spi_reg_bridge: RTL and testbench



---
 rtl/spi_reg_bridge.sv | 75 +++++++
 tb/tb_spi_reg_bridge.sv | 125 ++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: two-byte SPI command decoder with LED/scratch/status/count/ID registers
module spi_reg_bridge #(
  parameter logic [7:0] ID      = 8'h5A,
  parameter logic [7:0] LED_RST = 8'hFF
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       cs_n,
  input  logic [7:0] spi_dout,
  input  logic       spi_dout_vld,
  output logic [7:0] spi_din,
  output logic       spi_din_vld,
  input  logic       spi_ready,
  output logic [7:0] leds
);
  typedef enum logic [1:0] {IDLE, WR_DATA, RD_LOAD, RD_DUMMY} state_t;
  state_t state, state_nx;
  logic [2:0] cs_q;
  logic [7:0] regs [0:4];
  logic [7:0] cmd, wrcnt, rd_data;
  logic err, cs_end, in_ok, cmd_ok, take, wr_en, err_set, err_clr;
  logic [2:0] in_a;
  assign cs_end  = cs_q[1] & ~cs_q[2];
  assign in_a    = spi_dout[2:0];
  assign in_ok   = spi_dout[6:3] == 4'd0;
  assign cmd_ok  = cmd[6:3] == 4'd0;
  assign take    = state == IDLE && spi_dout_vld && !cs_end;
  assign wr_en   = state == WR_DATA && spi_dout_vld && !cs_end;
  assign err_set = (cs_end && state != IDLE) || (spi_dout_vld && !cs_end && (state == RD_LOAD || (state == WR_DATA && !cmd_ok)));
  assign err_clr = state == RD_DUMMY && spi_dout_vld && !cs_end && cmd == 8'h05;
  assign leds    = regs[0];
  // read mux evaluated on the incoming command byte so data is captured at decode
  always_comb
    rd_data = !in_ok ? 8'h00 : in_a <= 3'd4 ? regs[in_a] : in_a == 3'd5 ? {err, 7'b0} : in_a == 3'd6 ? wrcnt : ID;
  // two-flop synchroniser plus history flop for rising-edge detect of cs_n
  always_ff @(posedge clock)
    cs_q <= rst ? 3'b111 : {cs_q[1:0], cs_n};
  // state register
  always_ff @(posedge clock)
    state <= rst ? IDLE : state_nx;
  // next-state logic; end of chip select always wins
  always_comb begin
    state_nx = state;
    if (cs_end)
      state_nx = IDLE;
    else
      case (state)
        IDLE:     state_nx = spi_dout_vld ? (spi_dout[7] ? WR_DATA : RD_LOAD) : IDLE;
        WR_DATA:  state_nx = spi_dout_vld ? IDLE : WR_DATA;
        RD_LOAD:  state_nx = spi_dout_vld ? IDLE : spi_ready ? RD_DUMMY : RD_LOAD;
        default:  state_nx = spi_dout_vld ? IDLE : RD_DUMMY;
      endcase
  end
  // outputs: read data is offered only while waiting for the slave to take it
  always_comb
    spi_din_vld = state == RD_LOAD;
  // command latch, read capture, register writes, write counter and error flag
  always_ff @(posedge clock) begin
    if (rst) begin
      regs[0] <= LED_RST;
      for (int i = 1; i < 5; i++) regs[i] <= 8'h00;
      cmd     <= 8'h00;
      spi_din <= 8'h00;
      wrcnt   <= 8'h00;
      err     <= 1'b0;
    end else begin
      if (take) cmd <= spi_dout;
      if (take && !spi_dout[7]) spi_din <= rd_data;
      if (wr_en && cmd_ok) wrcnt <= wrcnt + 8'd1;
      if (wr_en && cmd_ok && cmd[2:0] <= 3'd4) regs[cmd[2:0]] <= spi_dout;
      if (err_set) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;
  logic clock = 0, rst = 1, cs_n = 0, spi_dout_vld = 0, spi_ready = 0;
  logic [7:0] spi_dout = 0;
  logic [7:0] spi_din, leds;
  logic spi_din_vld;
  int checks = 0, errors = 0;
  spi_reg_bridge dut (
    .clock(clock), .rst(rst), .cs_n(cs_n), .spi_dout(spi_dout), .spi_dout_vld(spi_dout_vld),
    .spi_din(spi_din), .spi_din_vld(spi_din_vld), .spi_ready(spi_ready), .leds(leds)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    spi_dout = b;
    spi_dout_vld = 1;
    tick;
    spi_dout_vld = 0;
  endtask
  task automatic wr(input logic [7:0] c, input logic [7:0] d);
    send_byte(c);
    send_byte(d);
  endtask
  task automatic rd(input string tag, input logic [7:0] c, input logic [7:0] exp);
    send_byte(c);
    check({tag, "_vld"}, {7'b0, spi_din_vld}, 8'h01);
    check(tag, spi_din, exp);
    spi_ready = 1;
    tick;
    spi_ready = 0;
    check({tag, "_vld_drop"}, {7'b0, spi_din_vld}, 8'h00);
    send_byte(8'h00);
  endtask
  task automatic cs_pulse;
    cs_n = 1;
    tick;
    cs_n = 0;
    tick;
    tick;
    tick;
  endtask
  initial begin
    tick;
    tick;
    check("rst_leds", leds, 8'hFF);
    check("rst_vld", {7'b0, spi_din_vld}, 8'h00);
    check("rst_din", spi_din, 8'h00);
    rst = 0;
    tick;
    rd("id", 8'h07, 8'h5A);
    wr(8'h81, 8'h3C);
    rd("reg1", 8'h01, 8'h3C);
    rd("wrcnt1", 8'h06, 8'h01);
    check("leds_before", leds, 8'hFF);
    wr(8'h80, 8'h55);
    check("leds_55", leds, 8'h55);
    wr(8'hC8, 8'hAA);
    rd("inv_wrcnt", 8'h06, 8'h02);
    rd("inv_reg1", 8'h01, 8'h3C);
    check("inv_leds", leds, 8'h55);
    rd("status_err", 8'h05, 8'h80);
    rd("status_clr", 8'h05, 8'h00);
    send_byte(8'h82);
    cs_pulse;
    rd("abort_reg2", 8'h02, 8'h00);
    rd("abort_status", 8'h05, 8'h80);
    wr(8'h82, 8'h11);
    rd("reg2", 8'h02, 8'h11);
    rd("wrcnt3", 8'h06, 8'h03);
    for (int i = 0; i < 252; i++) wr(8'h84, i[7:0]);
    rd("wrcnt_ff", 8'h06, 8'hFF);
    wr(8'h84, 8'hFC);
    rd("wrcnt_wrap", 8'h06, 8'h00);
    wr(8'h87, 8'h00);
    rd("id_ro", 8'h07, 8'h5A);
    rd("wrcnt_ro", 8'h06, 8'h01);
    send_byte(8'h04);
    for (int i = 0; i < 10; i++) begin
      check("hold_vld", {7'b0, spi_din_vld}, 8'h01);
      check("hold_din", spi_din, 8'hFC);
      tick;
    end
    spi_ready = 1;
    tick;
    spi_ready = 0;
    check("hold_drop", {7'b0, spi_din_vld}, 8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hAA);
    check("early_vld", {7'b0, spi_din_vld}, 8'h00);
    rd("early_status", 8'h05, 8'h80);
    rd("early_clr", 8'h05, 8'h00);
    cs_n = 1;
    tick;
    cs_n = 0;
    tick;
    send_byte(8'h81);
    tick;
    rd("csvld_id", 8'h07, 8'h5A);
    rd("csvld_reg1", 8'h01, 8'h3C);
    rd("csvld_status", 8'h05, 8'h00);
    send_byte(8'h81);
    rst = 1;
    tick;
    rst = 0;
    check("mid_rst_leds", leds, 8'hFF);
    check("mid_rst_vld", {7'b0, spi_din_vld}, 8'h00);
    rd("mid_rst_reg1", 8'h01, 8'h00);
    rd("mid_rst_wrcnt", 8'h06, 8'h00);
    wr(8'h80, 8'hA5);
    check("leds_a5", leds, 8'hA5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
